lif_tdm_scheduler: RTL

LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

---
 rtl/lif_tdm_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler
//   Time-multiplexed leaky integrate-and-fire array: N_NEUR virtual neurons
//   share one add/leak/threshold datapath. One neuron is processed per cycle
//   in round-robin order. When a neuron crosses THRESH, the scan stalls until
//   the resulting spike has been accepted through a valid/ready handshake.
//
//   Optional feature: define LIF_REFRACT_EN to add per-neuron refractory
//   counters. After a neuron fires, its next REFRACT processings hold it at 0
//   and drop any pending input event.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   in_spk     : per-neuron input events, sampled every cycle (sticky)
//   spk_valid  : a spike event is presented on spk_id
//   spk_ready  : consumer accepts the presented spike
//   spk_id     : index of the spiking neuron
//   frame_tick : one-cycle pulse after the scan index wraps N_NEUR-1 -> 0
module lif_tdm_scheduler #(
  parameter int N_NEUR  = 4,
  parameter int W       = 8,
  parameter int ADD     = 25,
  parameter int LEAK    = 1,
  parameter int THRESH  = 100,
  parameter int REFRACT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_NEUR-1:0]         in_spk,
  output logic                      spk_valid,
  input  logic                      spk_ready,
  output logic [$clog2(N_NEUR)-1:0] spk_id,
  output logic                      frame_tick
);

  localparam int              IW     = $clog2(N_NEUR);
  localparam logic [IW-1:0]   LAST   = IW'(N_NEUR - 1);
  localparam logic [W:0]      ADD_W  = (W + 1)'(ADD);
  localparam logic [W:0]      LEAK_W = (W + 1)'(LEAK);

  if (N_NEUR < 2 || N_NEUR > 16 || (N_NEUR & (N_NEUR - 1)) != 0 ||
      W < 1 || W > 31 || ADD < 0 || ADD >= (1 << W) || LEAK < 0 ||
      LEAK >= (1 << W) || REFRACT < 0) begin : g_param_check
    $error("lif_tdm_scheduler: unsupported parameter set");
  end

  typedef enum logic {SCAN, FIRE} state_t;

  state_t              state, state_nx;
  logic [W-1:0]        v [N_NEUR];
  logic [N_NEUR-1:0]   pend, pend_nx;
  logic [IW-1:0]       idx;
  logic [W:0]          sum, diff;
  logic [W-1:0]        v_upd;
  logic                fire, advance, in_refr;

`ifdef LIF_REFRACT_EN
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  logic [RW-1:0] rcnt [N_NEUR];
`endif

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    in_refr  = 1'b0;
    // Both candidates are formed one bit wider so carry/borrow drives saturation.
    sum      = {1'b0, v[idx]} + ADD_W;
    diff     = {1'b0, v[idx]} - LEAK_W;
    if (pend[idx]) v_upd = sum[W]  ? '1 : sum[W-1:0];
    else           v_upd = diff[W] ? '0 : diff[W-1:0];
`ifdef LIF_REFRACT_EN
    in_refr = (rcnt[idx] != '0);
    if (in_refr) v_upd = '0;
`endif
    fire = (state == SCAN) && !in_refr && (32'(v_upd) >= THRESH);

    case (state)
      SCAN: begin
        if (fire) state_nx = FIRE;
        else      advance  = 1'b1;
      end
      FIRE: begin
        if (spk_valid && spk_ready) begin
          state_nx = SCAN;
          advance  = 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase

    // An event arriving while its neuron is processed is kept for the next frame.
    pend_nx = pend | in_spk;
    if (state == SCAN) pend_nx[idx] = in_spk[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_NEUR; i++) v[i] <= '0;
      pend       <= '0;
      idx        <= '0;
      spk_valid  <= 1'b0;
      spk_id     <= '0;
      frame_tick <= 1'b0;
    end else begin
      pend       <= pend_nx;
      frame_tick <= advance && (idx == LAST);
      if (advance) idx <= idx + 1'b1;
      if (state == SCAN) v[idx] <= fire ? '0 : v_upd;
      if (fire) begin
        spk_valid <= 1'b1;
        spk_id    <= idx;
      end else if (spk_valid && spk_ready) begin
        spk_valid <= 1'b0;
      end
    end
  end

`ifdef LIF_REFRACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_NEUR; i++) rcnt[i] <= '0;
    end else if (state == SCAN) begin
      if (in_refr)   rcnt[idx] <= rcnt[idx] - 1'b1;
      else if (fire) rcnt[idx] <= RW'(REFRACT);
    end
  end
`endif

endmodule
